// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field positions and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned DEFAULT_PC_W = 32;
  localparam int unsigned INSTR_W      = 16;
  localparam int unsigned BUNDLE_W     = 32;

  // Opcode fields, as bit positions within a 16-bit instruction
  localparam int unsigned OPC1_MSB = 15;
  localparam int unsigned OPC1_LSB = 9;
  localparam int unsigned OPC1_W   = OPC1_MSB - OPC1_LSB + 1;
  localparam int unsigned OPC2_MSB = 15;
  localparam int unsigned OPC2_LSB = 11;
  localparam int unsigned OPC2_W   = OPC2_MSB - OPC2_LSB + 1;

  localparam logic [OPC1_W-1:0] NOP_OPC1 = '0;
  localparam logic [OPC2_W-1:0] NOP_OPC2 = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FULL
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched bundle and its PC while the
// IF/ID register is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = DEFAULT_PC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                drain,
  input  logic                clear,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [BUNDLE_W-1:0] in_bundle,
  output logic                valid,
  output logic [PC_W-1:0]     pc,
  output logic [BUNDLE_W-1:0] bundle
);

  logic                valid_q, valid_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [BUNDLE_W-1:0] bundle_q, bundle_d;

  // Clear and drain both win over load: the entry is being discarded or consumed.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    bundle_d = bundle_q;
    if (clear || drain) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      pc_d     = in_pc;
      bundle_d = in_bundle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      bundle_q <= bundle_d;
    end
  end

  assign valid  = valid_q;
  assign pc     = pc_q;
  assign bundle = bundle_q;

endmodule

// File: rtl/fetch_stage.sv
// Dual-issue fetch unit and IF/ID register: handles memory wait states,
// hazard stalls via a skid buffer, redirects and the exception vector.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_0040)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [BUNDLE_W-1:0] imem_data,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                exc_valid,
  input  logic [PC_W-1:0]     exc_pc,
  output logic                ifid_valid,
  output logic [PC_W-1:0]     ifid_pc,
  output logic [INSTR_W-1:0]  ifid_instr1,
  output logic [INSTR_W-1:0]  ifid_instr2,
  output logic [OPC1_W-1:0]   opcode1,
  output logic [OPC2_W-1:0]   opcode2,
  output logic [PC_W-1:0]     epc
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     epc_q, epc_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0]     ifid_pc_q, ifid_pc_d;
  logic [BUNDLE_W-1:0] ifid_bundle_q, ifid_bundle_d;

  logic                skid_load, skid_drain, skid_clear, skid_valid;
  logic [PC_W-1:0]     skid_pc;
  logic [BUNDLE_W-1:0] skid_bundle;
  logic [PC_W-1:0]     pc_next;

  assign pc_next = pc_q + PC_W'(4);

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk       (clk),
    .rst       (reset),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .in_pc     (pc_q),
    .in_bundle (imem_data),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .bundle    (skid_bundle)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_bundle_d = ifid_bundle_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    skid_clear    = 1'b0;

    if (exc_valid || redirect_valid) begin
      pc_d         = exc_valid ? EXC_VECTOR : redirect_pc;
      epc_d        = exc_valid ? exc_pc : epc_q;
      ifid_valid_d = 1'b0;
      skid_clear   = 1'b1;
      state_d      = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_valid && stall) begin
            skid_load = 1'b1;
            pc_d      = pc_next;
            state_d   = ST_FULL;
          end else if (imem_valid) begin
            ifid_valid_d  = 1'b1;
            ifid_pc_d     = pc_q;
            ifid_bundle_d = imem_data;
            pc_d          = pc_next;
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (!stall) begin
            ifid_valid_d  = skid_valid;
            ifid_pc_d     = skid_pc;
            ifid_bundle_d = skid_bundle;
            skid_drain    = 1'b1;
            state_d       = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      // NOTE: IF/ID data and epc are reset too, so no stale bundle is ever visible after reset.
      epc_q         <= '0;
      ifid_valid_q  <= 1'b0;
      ifid_pc_q     <= '0;
      ifid_bundle_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_bundle_q <= ifid_bundle_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr1 = ifid_bundle_q[BUNDLE_W-1:INSTR_W];
  assign ifid_instr2 = ifid_bundle_q[INSTR_W-1:0];
  assign epc         = epc_q;

  // Bubbles present NOP opcodes to the decoder.
  assign opcode1 = ifid_valid_q ? ifid_instr1[OPC1_MSB:OPC1_LSB] : NOP_OPC1;
  assign opcode2 = ifid_valid_q ? ifid_instr2[OPC2_MSB:OPC2_LSB] : NOP_OPC2;

endmodule
